dbg_access_seq: RTL and testbench
=================================

DBG_ACCESS_SEQ -- requirements
Module: dbg_access_seq

Interface
REQ-001 Parameters SHALL be: DW 32 data width (multiple of 8); AW 32 address width; NTGT 3 target count (0 dmem, 1 imem, 2 regfile); RD_LAT 1 read latency in cycles (>=1); TW 2 target-select width (>= clog2(NTGT)).
REQ-002 One clock; reset is synchronous and active-high. Ports SHALL be clk (in, 1) and reset (in, 1).
REQ-003 cmd_valid in 1 command offered; cmd_ready out 1 command accepted when both high at a clk edge.
REQ-004 cmd_wr in 1 (1 write, 0 read); cmd_tgt in TW target select; cmd_addr in AW address; cmd_wdata in DW write data; cmd_be in DW/8 byte enables; cmd_exp in DW expected read data.
REQ-005 rsp_valid out 1, rsp_ready in 1 response handshake; rsp_rdata out DW read data; rsp_err out 1 error flag.
REQ-006 mem_en out NTGT one-hot strobe; mem_we out DW/8 byte write enables; mem_addr out AW; mem_wdata out DW; mem_rdata in NTGT*DW, target t on bits [t*DW +: DW].
REQ-007 busy out 1 (state != IDLE); cmd_count out 16 completed responses; cmp_fail out 1 sticky compare failure; mis_count out 8 mismatch count.

Function
REQ-008 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-009 On accept, cmd fields SHALL be registered and the FSM SHALL move IDLE->ISSUE.
REQ-010 ISSUE SHALL last exactly one cycle: mem_en[tgt]=1, mem_addr/mem_wdata from registers, mem_we = cmd_be for writes, 0 for reads.
REQ-011 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last values.
REQ-012 Write: ISSUE->RESP; rsp_valid SHALL rise at the edge ending ISSUE; rsp_rdata SHALL be 0.
REQ-013 Read: ISSUE->WAIT; a down-counter SHALL load RD_LAT-1; rsp_rdata SHALL capture the target's mem_rdata slice at the edge exactly RD_LAT cycles after the edge ending ISSUE, entering RESP (RD_LAT=1 means WAIT lasts one cycle).
REQ-014 cmd_tgt >= NTGT SHALL issue no strobe; FSM SHALL go ISSUE->RESP with rsp_err=1, rsp_rdata=0.
REQ-015 In RESP, rsp_valid and rsp_rdata/rsp_err SHALL stay stable until rsp_ready; on handshake FSM SHALL go to IDLE and cmd_count SHALL increment, wrapping 16'hFFFF->0.
REQ-016 A new command SHALL NOT be accepted in the cycle of the response handshake; cmd_ready rises the next cycle.
REQ-017 Latency from accept edge to rsp_valid: 2 cycles for writes/invalid target, 2+RD_LAT for reads.

Reset
REQ-018 reset high at a clk edge SHALL force IDLE, regardless of state, aborting any in-flight command with no response.
REQ-019 Reset values: cmd_ready 0 during reset then 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; mem_en 0; mem_we 0; mem_addr 0; mem_wdata 0; busy 0; cmd_count 0; cmp_fail 0; mis_count 0.
REQ-020 A strobe in flight at reset SHALL be deasserted by that same edge.

Configuration
REQ-021 Macro DBG_CMP_EN SHALL compile in read-data comparison.
REQ-022 With DBG_CMP_EN: on read capture, if (rdata ^ cmd_exp) masked by cmd_be != 0, rsp_err SHALL be 1, cmp_fail SHALL set (sticky until reset), mis_count SHALL increment, saturating at 255.
REQ-023 Without DBG_CMP_EN: cmd_exp ignored; cmp_fail and mis_count tied 0; rsp_err set only by invalid target. Port list SHALL be identical in both builds.

Verification (DW=32, NTGT=3, RD_LAT=1)
REQ-024 Write tgt=0 addr=0x10 wdata=0xDEADBEEF be=4'hF -> one cycle mem_en=3'b001, mem_we=4'hF, mem_addr=0x10; rsp_valid 2 cycles after accept, rsp_err=0, cmd_count=1.
REQ-025 Read tgt=2 addr=5 with mem_rdata[95:64]=0x12345678 -> mem_en=3'b100, mem_we=0; rsp_rdata=0x12345678 at accept+3; rsp_ready held low 4 cycles -> rsp_valid/rsp_rdata stable.
REQ-026 cmd_tgt=3 -> mem_en stays 0; rsp_err=1, rsp_rdata=0, rsp_valid at accept+2.
REQ-027 Reset asserted during WAIT of a read -> next cycle busy=0, rsp_valid=0, mem_en=0, cmd_count=0; no response ever emitted.
REQ-028 DBG_CMP_EN: read returning 0x000000FF, cmd_exp=0x000000FE, be=4'h1 -> rsp_err=1, cmp_fail=1, mis_count=1; same with be=4'h2 -> rsp_err=0; 300 mismatches -> mis_count=255.

Source files
------------

// File: rtl/dbg_access_seq.sv
// Debug access sequencer: accepts single read/write commands, drives one
// memory-target strobe cycle, waits out the read latency and holds a response
// until it is taken. Defining DBG_CMP_EN compiles in read-data comparison
// against cmd_exp (sticky cmp_fail, saturating mis_count).
module dbg_access_seq #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned NTGT   = 3,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [TW-1:0]        cmd_tgt,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [DW-1:0]        cmd_wdata,
  input  logic [DW/8-1:0]      cmd_be,
  input  logic [DW-1:0]        cmd_exp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [NTGT-1:0]      mem_en,
  output logic [DW/8-1:0]      mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [NTGT*DW-1:0]   mem_rdata,
  output logic                 busy,
  output logic [15:0]          cmd_count,
  output logic                 cmp_fail,
  output logic [7:0]           mis_count
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LatLoad = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [TW-1:0]   tgt_q, tgt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     cmd_count_q, cmd_count_d;

  logic            tgt_ok;
  logic [DW-1:0]   rdata_sel;
  logic            mismatch;

  assign tgt_ok = 32'(tgt_q) < NTGT;

  // Select the addressed target's read-data slice.
  always_comb begin
    rdata_sel = '0;
    for (int unsigned t = 0; t < NTGT; t++) begin
      if (tgt_q == TW'(t)) rdata_sel = mem_rdata[t*DW +: DW];
    end
  end

`ifdef DBG_CMP_EN
  logic [DW-1:0] exp_q;
  logic [DW-1:0] be_mask;
  logic          cmp_fail_q, cmp_fail_d;
  logic [7:0]    mis_count_q, mis_count_d;

  // Expand byte enables into a bit mask for the compare.
  always_comb begin
    be_mask = '0;
    for (int unsigned b = 0; b < BW; b++) begin
      be_mask[b*8 +: 8] = {8{be_q[b]}};
    end
  end

  assign mismatch  = |((rdata_sel ^ exp_q) & be_mask);
  assign cmp_fail  = cmp_fail_q;
  assign mis_count = mis_count_q;

  // Expected-data register and compare statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q       <= '0;
      cmp_fail_q  <= 1'b0;
      mis_count_q <= '0;
    end else begin
      if (state_q == StIdle && cmd_valid) exp_q <= cmd_exp;
      cmp_fail_q  <= cmp_fail_d;
      mis_count_q <= mis_count_d;
    end
  end

  // A mismatch is only counted on the read-capture edge.
  always_comb begin
    cmp_fail_d  = cmp_fail_q;
    mis_count_d = mis_count_q;
    if (state_q == StWait && cnt_q == '0 && mismatch) begin
      cmp_fail_d = 1'b1;
      if (mis_count_q != 8'hFF) mis_count_d = mis_count_q + 8'd1;
    end
  end
`else
  logic unused_cmd_exp;
  assign unused_cmd_exp = ^cmd_exp;
  assign mismatch       = 1'b0;
  assign cmp_fail       = 1'b0;
  assign mis_count      = 8'd0;
`endif

  // Main state and command/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      tgt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  // Next-state logic for the access sequence.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cmd_count_d = cmd_count_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          wr_d    = cmd_wr;
          tgt_d   = cmd_tgt;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          be_d    = cmd_be;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!tgt_ok || wr_q) begin
          // Writes and bad targets respond immediately with no read data.
          err_d   = !tgt_ok;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d   = LatLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rdata_d = rdata_sel;
          err_d   = mismatch;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory strobes are only live during the single ISSUE cycle.
  always_comb begin
    mem_en = '0;
    mem_we = '0;
    if (state_q == StIssue) begin
      for (int unsigned t = 0; t < NTGT; t++) begin
        mem_en[t] = (tgt_q == TW'(t));
      end
      if (wr_q && tgt_ok) mem_we = be_q;
    end
  end

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_dbg_access_seq.sv
// Testbench for dbg_access_seq: directed scenarios plus randomized commands,
// checked against a transaction-level reference model.
module tb_dbg_access_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NTGT = 3;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned TW = 2;
`ifdef DBG_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [TW-1:0]    cmd_tgt;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [DW/8-1:0]  cmd_be;
  logic [DW-1:0]    cmd_exp;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [NTGT-1:0]  mem_en;
  logic [DW/8-1:0]  mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [NTGT*DW-1:0] mem_rdata;
  logic             busy;
  logic [15:0]      cmd_count;
  logic             cmp_fail;
  logic [7:0]       mis_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_count = '0;
  int          m_mis = 0;
  bit          m_fail = 1'b0;

  dbg_access_seq #(
    .DW(DW), .AW(AW), .NTGT(NTGT), .RD_LAT(RD_LAT), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_tgt(cmd_tgt),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_exp(cmd_exp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .cmd_count(cmd_count), .cmp_fail(cmp_fail),
    .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full command: offer, observe strobe, wait for response, hold, handshake.
  task automatic do_cmd(input bit wr, input logic [1:0] tgt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp, input logic [95:0] bus,
                        input int hold, input string tag);
    logic [31:0] slice;
    logic [31:0] mask;
    logic [2:0]  exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_rdata;
    bit          valid_tgt, is_read, mism, exp_err, got;
    int          exp_lat, k;

    valid_tgt = (tgt < 2'd3);
    case (tgt)
      2'd0:    slice = bus[31:0];
      2'd1:    slice = bus[63:32];
      2'd2:    slice = bus[95:64];
      default: slice = 32'h0;
    endcase
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    exp_en    = valid_tgt ? (3'b001 << tgt) : 3'b000;
    exp_we    = (valid_tgt && wr) ? be : 4'h0;
    is_read   = valid_tgt && !wr;
    mism      = CMP && is_read && (((slice ^ exp) & mask) != 32'h0);
    exp_rdata = is_read ? slice : 32'h0;
    exp_err   = !valid_tgt || mism;
    exp_lat   = is_read ? 2 + int'(RD_LAT) : 2;
    if (mism) begin
      m_fail = 1'b1;
      if (m_mis < 255) m_mis++;
    end

    // Cycle 0: offer the command
    cmd_wr = wr; cmd_tgt = tgt; cmd_addr = addr; cmd_wdata = wdata;
    cmd_be = be; cmd_exp = exp; mem_rdata = bus; cmd_valid = 1'b1;
    check({tag, "_ready"}, 64'(cmd_ready), 64'd1);

    // Cycle 1: the ISSUE cycle
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_be = ~be;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_en"}, 64'(mem_en), 64'(exp_en));
    check({tag, "_we"}, 64'(mem_we), 64'(exp_we));
    check({tag, "_addr"}, 64'(mem_addr), 64'(addr));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
    check({tag, "_early_valid"}, 64'(rsp_valid), 64'd0);

    got = 1'b0;
    k = 1;
    for (int c = 2; c <= 24 && !got; c++) begin
      @(negedge clk);
      k = c;
      if (c == 2) check({tag, "_en_off"}, 64'({mem_en, mem_we}), 64'd0);
      if (rsp_valid) got = 1'b1;
    end
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));

    // Response must stay stable while the consumer stalls
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      mem_rdata = {$urandom, $urandom, $urandom};
      check({tag, "_hold"}, {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, exp_rdata});
      check({tag, "_hold_err"}, 64'(rsp_err), 64'(exp_err));
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    m_count = m_count + 16'd1;
    check({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_count"}, 64'(cmd_count), 64'(m_count));
    check({tag, "_cmp_fail"}, 64'(cmp_fail), 64'(m_fail));
    check({tag, "_mis"}, 64'(mis_count), 64'(m_mis));
  endtask

  // Start a read, then reset it at cycle at_k after the offer.
  task automatic reset_mid(input int at_k, input string tag);
    bit seen;
    cmd_wr = 1'b0; cmd_tgt = 2'd1; cmd_addr = 32'h40; cmd_wdata = $urandom;
    cmd_be = 4'hF; cmd_exp = 32'h0; mem_rdata = {$urandom, $urandom, $urandom};
    cmd_valid = 1'b1;
    for (int k = 1; k <= at_k; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    if (at_k == 1) check({tag, "_en_before"}, 64'(mem_en), 64'd2);
    check({tag, "_busy_before"}, 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_en"}, 64'(mem_en), 64'd0);
    check({tag, "_count"}, 64'(cmd_count), 64'd0);
    check({tag, "_ready_in_reset"}, 64'(cmd_ready), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    reset = 1'b0;
    m_count = '0; m_mis = 0; m_fail = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check({tag, "_no_rsp"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [95:0] bus;
    logic [31:0] e;
    bit          wr;
    logic [1:0]  tgt;

    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_tgt = '0; cmd_addr = '0;
    cmd_wdata = '0; cmd_be = '0; cmd_exp = '0; rsp_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_count", 64'(cmd_count), 64'd0);
    check("rst_cmp_fail", 64'(cmp_fail), 64'd0);
    check("rst_mis_count", 64'(mis_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 64'(cmd_ready), 64'd1);

    // Basic write, stalled read from regfile, invalid target
    do_cmd(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 96'h0, 0, "wr_dmem");
    bus = {32'h12345678, 32'($urandom), 32'($urandom)};
    do_cmd(1'b0, 2'd2, 32'h5, 32'h0, 4'hF, 32'h12345678, bus, 4, "rd_rf");
    do_cmd(1'b1, 2'd3, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 96'h0, 0, "bad_tgt_wr");
    bus = {32'($urandom), 32'($urandom), 32'($urandom)};
    do_cmd(1'b0, 2'd3, 32'h24, 32'h0, 4'hF, 32'h0, bus, 1, "bad_tgt_rd");

    // Reset during WAIT and during ISSUE
    reset_mid(2, "rst_wait");
    reset_mid(1, "rst_issue");

    // Masked compare: byte 0 differs, byte 1 equal
    bus = {64'h0, 32'h000000FF};
    do_cmd(1'b0, 2'd0, 32'h8, 32'h0, 4'h1, 32'h000000FE, bus, 0, "cmp_be1");
    do_cmd(1'b0, 2'd0, 32'h8, 32'h0, 4'h2, 32'h000000FE, bus, 0, "cmp_be2");

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom);
      tgt = 2'($urandom_range(0, 3));
      bus = {32'($urandom), 32'($urandom), 32'($urandom)};
      e   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        case (tgt)
          2'd0: e = bus[31:0];
          2'd1: e = bus[63:32];
          default: e = bus[95:64];
        endcase
        e = e ^ (32'h1 << $urandom_range(0, 31));
      end
      do_cmd(wr, tgt, $urandom, $urandom, 4'($urandom), e, bus,
             int'($urandom_range(0, 3)), "rand");
    end

    // Many mismatching reads: the mismatch counter must saturate
    for (int i = 0; i < 300; i++) begin
      bus = {32'($urandom), 32'hA5A5A5A5, 32'($urandom)};
      do_cmd(1'b0, 2'd1, 32'(i), 32'h0, 4'hF, 32'h5A5A5A5A, bus, 0, "sat");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
